// File: rtl/abc_instruction_ram.sv
// CoreABC instruction store: single-port RAM with a fetch port and an APB port for load/readback.
// Optional stored even parity per word is enabled by defining ABC_IMEM_PARITY_EN.
module abc_instruction_ram #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int ICWIDTH = 8,
  parameter int ICDEPTH = 256,
  parameter int IWWIDTH = 58
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [ICWIDTH-1:0] ADDRESS,
  output logic               STALL,
  output logic [IWWIDTH-1:0] INSTRUCTION,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [AWIDTH-1:0]  PADDR,
  input  logic [DWIDTH-1:0]  PWDATA,
  output logic [DWIDTH-1:0]  PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic               PARITY_ERR
);

  localparam int NSLICES = (IWWIDTH + DWIDTH - 1) / DWIDTH;
  localparam int SW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam int SWW     = NSLICES * DWIDTH;
`ifdef ABC_IMEM_PARITY_EN
  localparam int MW      = IWWIDTH + 1;
`else
  localparam int MW      = IWWIDTH;
`endif
  localparam logic [SW-1:0]      LAST_SLICE = SW'(NSLICES - 1);
  localparam logic [ICWIDTH:0]   DEPTH_L    = (ICWIDTH + 1)'(ICDEPTH);

  logic [MW-1:0]      mem_q [ICDEPTH];
  logic [MW-1:0]      ram_rd_q;
  logic [ICWIDTH-1:0] idx_q, idx_d;
  logic [SW-1:0]      slice_q, slice_d;
  logic [SWW-1:0]     stage_q, stage_d;
  logic               hold_q, hold_d;
  logic               rd_pend_q, rd_pend_d;
  logic [DWIDTH-1:0]  prdata_q, prdata_d;
  logic               par_err_q, par_err_d;
  logic               fetch_vld_q, fetch_ok_q;
  logic [IWWIDTH-1:0] instr_hold_q;

  logic               acc, wr_data, rd_data, rd_cyc1, rd_cyc2;
  logic               last_slice, idx_ok, addr_ok, commit, mem_we;
  logic               fetch_conflict, fetch_go, par_mismatch;
  logic [1:0]         reg_sel;
  logic [ICWIDTH-1:0] ram_addr;
  logic [IWWIDTH-1:0] commit_word;
  logic [MW-1:0]      mem_wdata;
  logic [SWW-1:0]     rd_word;
  logic [DWIDTH-1:0]  rd_slice;
  logic               unused_paddr;

  assign unused_paddr = ^{PADDR[AWIDTH-1:4], PADDR[1:0]};

  assign reg_sel    = PADDR[3:2];
  assign acc        = PSEL & PENABLE;
  assign wr_data    = acc & PWRITE & (reg_sel == 2'd1);
  assign rd_data    = acc & ~PWRITE & (reg_sel == 2'd1);
  assign rd_cyc1    = rd_data & ~rd_pend_q;
  assign rd_cyc2    = rd_data & rd_pend_q;
  assign last_slice = (slice_q == LAST_SLICE);
  assign idx_ok     = ({1'b0, idx_q} < DEPTH_L);
  assign addr_ok    = ({1'b0, ADDRESS} < DEPTH_L);
  assign commit     = wr_data & last_slice;
  assign mem_we     = commit & idx_ok;

  // APB owns the single RAM port during a commit or the first read cycle.
  assign fetch_conflict = commit | rd_cyc1 | hold_q;
  assign STALL          = START & fetch_conflict;
  assign fetch_go       = START & ~fetch_conflict;
  assign ram_addr       = rd_cyc1 ? idx_q : ADDRESS;

  assign commit_word = stage_d[IWWIDTH-1:0];
`ifdef ABC_IMEM_PARITY_EN
  assign mem_wdata    = {^commit_word, commit_word};
  assign par_mismatch = ^ram_rd_q;
`else
  assign mem_wdata    = commit_word;
  assign par_mismatch = 1'b0;
`endif

  assign rd_word  = SWW'(ram_rd_q[IWWIDTH-1:0]);
  assign rd_slice = rd_word[int'(slice_q) * DWIDTH +: DWIDTH];

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx_q] <= mem_wdata;
    if (rd_cyc1 | fetch_go) ram_rd_q <= mem_q[ram_addr];
  end

  // The RAM output register serves fetch data for one cycle; instr_hold_q keeps it afterwards.
  assign INSTRUCTION = fetch_vld_q ? (fetch_ok_q ? ram_rd_q[IWWIDTH-1:0] : '0) : instr_hold_q;

  assign PREADY  = ~rd_cyc1;
  assign PSLVERR = acc & ((reg_sel == 2'd3) | (wr_data & ~idx_ok) |
                          (rd_cyc2 & (~idx_ok | par_mismatch)));
  assign PRDATA     = prdata_d;
  assign PARITY_ERR = par_err_q;

  always_comb begin
    idx_d     = idx_q;
    slice_d   = slice_q;
    stage_d   = stage_q;
    hold_d    = hold_q;
    rd_pend_d = rd_cyc1;
    prdata_d  = prdata_q;
    par_err_d = par_err_q;

    if (wr_data) stage_d[int'(slice_q) * DWIDTH +: DWIDTH] = PWDATA;

    if (wr_data | rd_cyc2) begin
      if (last_slice) begin
        slice_d = '0;
        idx_d   = idx_q + 1'b1;
      end else begin
        slice_d = slice_q + 1'b1;
      end
    end

    if (acc & PWRITE) begin
      case (reg_sel)
        2'd0: begin
          idx_d   = ICWIDTH'(PWDATA);
          slice_d = '0;
        end
        2'd2: begin
          hold_d = PWDATA[0];
`ifdef ABC_IMEM_PARITY_EN
          if (PWDATA[1]) par_err_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end

    if (acc & ~PWRITE) begin
      case (reg_sel)
        2'd0:    prdata_d = DWIDTH'(idx_q);
        2'd1:    if (rd_cyc2) prdata_d = idx_ok ? rd_slice : '0;
        2'd2:    prdata_d = DWIDTH'({par_err_q, hold_q});
        default: ;
      endcase
    end

    // A new error wins over a same-cycle clear so no mismatch is ever lost.
    if ((fetch_vld_q & fetch_ok_q & par_mismatch) | (rd_cyc2 & idx_ok & par_mismatch))
      par_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q        <= '0;
      slice_q      <= '0;
      stage_q      <= '0;
      hold_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      prdata_q     <= '0;
      par_err_q    <= 1'b0;
      fetch_vld_q  <= 1'b0;
      fetch_ok_q   <= 1'b0;
      instr_hold_q <= '0;
    end else begin
      idx_q        <= idx_d;
      slice_q      <= slice_d;
      stage_q      <= stage_d;
      hold_q       <= hold_d;
      rd_pend_q    <= rd_pend_d;
      prdata_q     <= prdata_d;
      par_err_q    <= par_err_d;
      fetch_vld_q  <= fetch_go;
      fetch_ok_q   <= fetch_go ? addr_ok : fetch_ok_q;
      instr_hold_q <= INSTRUCTION;
    end
  end

endmodule
